prog_pulse_timer: RTL and testbench
===================================

PROG_PULSE_TIMER -- requirements
Module: prog_pulse_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter and period width in bits (range 2..32).
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 200, period register value after reset (must fit in CNT_W bits).
REQ-003 SHALL have port pulseClk, input, 1 bit, sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, start the timer, or restart it while running.
REQ-006 SHALL have port stop, input, 1 bit, abort the timer.
REQ-007 SHALL have port oneShot, input, 1 bit, mode select: 1 = single period, 0 = periodic; sampled on every terminal count.
REQ-008 SHALL have port loadPeriod, input, 1 bit, strobe to write periodIn into the period register.
REQ-009 SHALL have port periodIn, input, CNT_W bits, new period value P.
REQ-010 SHALL have port pulseOut, output, 1 bit, single-cycle terminal-count pulse.
REQ-011 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-012 SHALL have port LED, output, 1 bit, equal to busy.
REQ-013 SHALL have port count, output, CNT_W bits, current counter value.

Function
REQ-014 SHALL implement two states: IDLE and RUN.
REQ-015 IDLE: counter holds 0; start SHALL move to RUN with counter 0 on the next cycle.
REQ-016 RUN: counter SHALL increment by 1 per advance; when counter == P on an advance, pulseOut SHALL be 1 for exactly the following cycle.
REQ-017 Terminal count with oneShot=0 SHALL reset the counter to 0 and stay in RUN, giving period P+1 advances.
REQ-018 Terminal count with oneShot=1 SHALL go to IDLE with counter 0.
REQ-019 P=0 with periodic mode SHALL pulse on every advance; pulseOut stays continuously high.
REQ-020 start in RUN SHALL retrigger: counter to 0 and no pulse that cycle, even if counter == P.
REQ-021 stop SHALL force IDLE, counter 0 and no pulse; stop and start together means stop wins.
REQ-022 loadPeriod SHALL update the period register in any state; the new value is compared from the next cycle on.
REQ-023 If a load lowers P below the current count, the counter SHALL wrap at 2^CNT_W-1 to 0 and continue to the new P; it SHALL NOT pulse early.
REQ-024 The counter SHALL never exceed P except in the REQ-023 case; arithmetic SHALL be modulo 2^CNT_W.

Reset
REQ-025 rst SHALL produce state IDLE, counter 0, pulseOut 0, busy 0, LED 0, period register DEFAULT_PERIOD, and prescaler 0.
REQ-026 rst SHALL override every other input in the same cycle, including mid-period; no pulse is emitted.

Configuration
REQ-027 Macro TIMER_PRESCALE_EN defined: the module SHALL add input prescale (4 bits, value S).
REQ-028 With the macro defined, the counter SHALL advance only once every S+1 clocks.
REQ-029 With the macro defined, the prescaler SHALL be cleared on start, stop, terminal count and rst.
REQ-030 With the macro defined, prescale SHALL be sampled each clock.
REQ-031 Macro undefined: the prescale port SHALL be absent and the counter SHALL advance every clock in RUN.

Structure
REQ-032 Package timer_pkg SHALL hold the state enum (IDLE, RUN) and the prescaler width constant (4).
REQ-033 The prescaler SHALL be a sub-module tick_prescaler producing a one-cycle advance strobe; it is compiled only under TIMER_PRESCALE_EN.

Verification
REQ-034 Reset release, start at cycle 0, P=200, periodic: pulseOut high at cycles 201, 402 and 603; busy and LED stay 1.
REQ-035 P=3, oneShot=1, start: pulseOut high exactly once, 4 cycles after start; then busy=0 and count=0.
REQ-036 P=10, periodic, start again at count=7: count goes to 0 and the next pulse comes 11 cycles after the retrigger.
REQ-037 stop and start together at count=5: IDLE, count 0, and no pulse for 50 cycles.
REQ-038 count=8 with P=10, load periodIn=4: no pulse until the counter wraps; CNT_W=4 gives the next pulse after 12 further cycles.
REQ-039 TIMER_PRESCALE_EN with S=2, P=2: pulseOut high every 9 clocks; rst asserted mid-period clears all outputs on the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable pulse timer.
package timer_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } timer_state_e;

    localparam int unsigned PrescaleW = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-cycle advance strobe every limit_i+1 enabled clocks.
module tick_prescaler #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] limit_i,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // >= keeps the strobe coming if limit_i drops below the running count.
    assign tick_o = en_i && (cnt_q >= limit_i);

    always_comb begin
        cnt_d = cnt_q + Width'(1);
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_pulse_timer.sv
// Programmable one-shot/periodic pulse timer with a loadable period register.
// Define TIMER_PRESCALE_EN to add the 4-bit prescale input and its clock divider.
module prog_pulse_timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEFAULT_PERIOD = 200
) (
    input  logic                 pulseClk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 oneShot,
    input  logic                 loadPeriod,
    input  logic [CNT_W-1:0]     periodIn,
`ifdef TIMER_PRESCALE_EN
    input  logic [PrescaleW-1:0] prescale,
`endif
    output logic                 pulseOut,
    output logic                 busy,
    output logic                 LED,
    output logic [CNT_W-1:0]     count
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pulse_q, pulse_d;
    logic             advance;

`ifdef TIMER_PRESCALE_EN
    // Terminal count needs no explicit clear: the divider restarts on every strobe.
    tick_prescaler #(
        .Width (PrescaleW)
    ) u_tick_prescaler (
        .clk_i   (pulseClk),
        .rst_i   (rst),
        .en_i    (state_q == StRun),
        .clr_i   (start | stop),
        .limit_i (prescale),
        .tick_o  (advance)
    );
`else
    assign advance = (state_q == StRun);
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pulse_d  = 1'b0;
        period_d = loadPeriod ? periodIn : period_q;

        if (stop) begin
            state_d = StIdle;
            count_d = '0;
        end else if (start) begin
            state_d = StRun;
            count_d = '0;
        end else if ((state_q == StRun) && advance) begin
            // Equality only, so a lowered period lets the counter wrap instead of firing early.
            if (count_q == period_q) begin
                pulse_d = 1'b1;
                count_d = '0;
                if (oneShot) begin
                    state_d = StIdle;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pulseClk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulseOut = pulse_q;
    assign busy     = (state_q == StRun);
    assign LED      = busy;
    assign count    = count_q;

endmodule

// File: tb/tb_prog_pulse_timer.sv
// Directed self-checking bench for prog_pulse_timer (16-bit default and 4-bit instances).
module tb_prog_pulse_timer;

    logic        clk = 1'b0;
    logic        rst, start, stop, oneShot, loadPeriod;
    logic [15:0] periodIn;
    logic        pulseOut, busy, LED;
    logic [15:0] count;
`ifdef TIMER_PRESCALE_EN
    logic [3:0]  prescale;
    logic [3:0]  prescale_w;
`endif

    logic        start_w, stop_w, oneShot_w, loadPeriod_w;
    logic [3:0]  periodIn_w;
    logic        pulseOut_w, busy_w, LED_w;
    logic [3:0]  count_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prog_pulse_timer #(
        .CNT_W          (16),
        .DEFAULT_PERIOD (200)
    ) dut (
        .pulseClk   (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .oneShot    (oneShot),
        .loadPeriod (loadPeriod),
        .periodIn   (periodIn),
`ifdef TIMER_PRESCALE_EN
        .prescale   (prescale),
`endif
        .pulseOut   (pulseOut),
        .busy       (busy),
        .LED        (LED),
        .count      (count)
    );

    prog_pulse_timer #(
        .CNT_W          (4),
        .DEFAULT_PERIOD (10)
    ) dut_w (
        .pulseClk   (clk),
        .rst        (rst),
        .start      (start_w),
        .stop       (stop_w),
        .oneShot    (oneShot_w),
        .loadPeriod (loadPeriod_w),
        .periodIn   (periodIn_w),
`ifdef TIMER_PRESCALE_EN
        .prescale   (prescale_w),
`endif
        .pulseOut   (pulseOut_w),
        .busy       (busy_w),
        .LED        (LED_w),
        .count      (count_w)
    );

    // Inputs set before step() are sampled at that edge; outputs are read 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; oneShot = 1'b0;
        step();
        step();
        start = 1'b0;
        n_checks++;
        if ({pulseOut, busy, LED, count} !== 19'd0)
            $display("FAIL reset_main: got p=%b b=%b l=%b c=%0d, want all 0", pulseOut, busy, LED, count);
        else n_pass++;
        n_checks++;
        if ({pulseOut_w, busy_w, LED_w, count_w} !== 7'd0)
            $display("FAIL reset_narrow: got p=%b b=%b c=%0d, want all 0", pulseOut_w, busy_w, count_w);
        else n_pass++;
        rst = 1'b0;
    endtask

    // Default period 200, periodic: pulses after edges 201, 402, 603.
    task automatic test_periodic();
        int bad;
        oneShot = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || count !== 16'd0)
            $display("FAIL periodic_start: got busy=%b count=%0d, want 1/0", busy, count);
        else n_pass++;
        bad = 0;
        for (int k = 1; k <= 603; k++) begin
            step();
            n_checks++;
            if (pulseOut !== (k % 201 == 0) || count !== 16'(k % 201) || busy !== 1'b1 || LED !== 1'b1) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL periodic k=%0d: got p=%b c=%0d b=%b l=%b, want p=%b c=%0d b=1 l=1",
                             k, pulseOut, count, busy, LED, (k % 201 == 0), k % 201);
            end else n_pass++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || LED !== 1'b0 || count !== 16'd0 || pulseOut !== 1'b0)
            $display("FAIL periodic_stop: got b=%b l=%b c=%0d p=%b, want 0", busy, LED, count, pulseOut);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        loadPeriod = 1'b1; periodIn = 16'd3;
        step();
        loadPeriod = 1'b0;
        oneShot = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (pulseOut !== (k == 4) || busy !== (k < 4) || count !== (k < 4 ? 16'(k) : 16'd0))
                $display("FAIL oneshot k=%0d: got p=%b b=%b c=%0d, want p=%b b=%b c=%0d",
                         k, pulseOut, busy, count, (k == 4), (k < 4), (k < 4 ? k : 0));
            else n_pass++;
        end
        oneShot = 1'b0;
    endtask

    task automatic test_retrigger();
        loadPeriod = 1'b1; periodIn = 16'd10; start = 1'b1;
        step();
        loadPeriod = 1'b0; start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        n_checks++;
        if (count !== 16'd7) $display("FAIL retrig_pre: got count=%0d, want 7", count);
        else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (count !== 16'd0 || pulseOut !== 1'b0 || busy !== 1'b1)
            $display("FAIL retrig_edge: got c=%0d p=%b b=%b, want 0/0/1", count, pulseOut, busy);
        else n_pass++;
        for (int k = 1; k <= 22; k++) begin
            step();
            n_checks++;
            if (pulseOut !== (k == 11 || k == 22) || count !== 16'(k % 11))
                $display("FAIL retrig k=%0d: got p=%b c=%0d, want p=%b c=%0d",
                         k, pulseOut, count, (k == 11 || k == 22), k % 11);
            else n_pass++;
        end
        // Restart exactly at terminal count must suppress the pulse.
        for (int k = 0; k < 10; k++) step();
        n_checks++;
        if (count !== 16'd10) $display("FAIL retrig_at_p_pre: got count=%0d, want 10", count);
        else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (pulseOut !== 1'b0 || count !== 16'd0)
            $display("FAIL retrig_at_p: got p=%b c=%0d, want 0/0", pulseOut, count);
        else n_pass++;
    endtask

    task automatic test_stop_start();
        int bad;
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (count !== 16'd5) $display("FAIL stopstart_pre: got count=%0d, want 5", count);
        else n_pass++;
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || count !== 16'd0 || pulseOut !== 1'b0)
            $display("FAIL stopstart_edge: got b=%b c=%0d p=%b, want 0", busy, count, pulseOut);
        else n_pass++;
        bad = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (pulseOut !== 1'b0 || busy !== 1'b0 || count !== 16'd0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL stopstart_idle: got %0d bad cycles, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_zero_period();
        loadPeriod = 1'b1; periodIn = 16'd0; start = 1'b1;
        step();
        loadPeriod = 1'b0; start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if (pulseOut !== 1'b1 || count !== 16'd0 || busy !== 1'b1)
                $display("FAIL zero_period k=%0d: got p=%b c=%0d b=%b, want 1/0/1", k, pulseOut, count, busy);
            else n_pass++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (pulseOut !== 1'b0 || busy !== 1'b0)
            $display("FAIL zero_period_stop: got p=%b b=%b, want 0/0", pulseOut, busy);
        else n_pass++;
    endtask

    // 4-bit timer at count 8, P=10 lowered to 4: wraps through 15 and pulses 12 edges later.
    task automatic test_load_lower();
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        for (int k = 0; k < 8; k++) step();
        n_checks++;
        if (count_w !== 4'd8) $display("FAIL lower_pre: got count=%0d, want 8", count_w);
        else n_pass++;
        loadPeriod_w = 1'b1; periodIn_w = 4'd4;
        step();
        loadPeriod_w = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            n_checks++;
            if (pulseOut_w !== 1'b0 || count_w !== 4'((9 + k) % 16))
                $display("FAIL lower k=%0d: got p=%b c=%0d, want p=0 c=%0d", k, pulseOut_w, count_w, (9 + k) % 16);
            else n_pass++;
        end
        step();
        n_checks++;
        if (pulseOut_w !== 1'b1 || count_w !== 4'd0)
            $display("FAIL lower_pulse: got p=%b c=%0d, want 1/0", pulseOut_w, count_w);
        else n_pass++;
        stop_w = 1'b1;
        step();
        stop_w = 1'b0;
    endtask

    task automatic test_reset_mid();
        loadPeriod = 1'b1; periodIn = 16'd10; start = 1'b1;
        step();
        loadPeriod = 1'b0; start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        n_checks++;
        if (count !== 16'd10) $display("FAIL rstmid_pre: got count=%0d, want 10", count);
        else n_pass++;
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if ({pulseOut, busy, LED, count} !== 19'd0)
            $display("FAIL rstmid: got p=%b b=%b l=%b c=%0d, want all 0", pulseOut, busy, LED, count);
        else n_pass++;
        // Period register must be back at 200: no pulse at edge 11, pulse at edge 201.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 201; k++) begin
            step();
            if (k == 11 || k == 201) begin
                n_checks++;
                if (pulseOut !== (k == 201))
                    $display("FAIL rstmid_default k=%0d: got p=%b, want %b", k, pulseOut, (k == 201));
                else n_pass++;
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        prescale = 4'd2;
        loadPeriod = 1'b1; periodIn = 16'd2; start = 1'b1;
        step();
        loadPeriod = 1'b0; start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            n_checks++;
            if (pulseOut !== (k % 9 == 0) || count !== 16'((k / 3) % 3))
                $display("FAIL prescale k=%0d: got p=%b c=%0d, want p=%b c=%0d",
                         k, pulseOut, count, (k % 9 == 0), (k / 3) % 3);
            else n_pass++;
        end
        for (int k = 0; k < 8; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({pulseOut, busy, LED, count} !== 19'd0)
            $display("FAIL prescale_rst: got p=%b b=%b l=%b c=%0d, want all 0", pulseOut, busy, LED, count);
        else n_pass++;
        prescale = 4'd0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; oneShot = 1'b0;
        loadPeriod = 1'b0; periodIn = '0;
        start_w = 1'b0; stop_w = 1'b0; oneShot_w = 1'b0;
        loadPeriod_w = 1'b0; periodIn_w = '0;
`ifdef TIMER_PRESCALE_EN
        prescale = 4'd0; prescale_w = 4'd0;
`endif
        test_reset();
        test_periodic();
        test_oneshot();
        test_retrigger();
        test_stop_start();
        test_zero_period();
        test_load_lower();
        test_reset_mid();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
